// File: rtl/xor_mask_feeder.sv
// rtl/xor_mask_feeder.sv - LFSR-driven share/randomness feeder for a 2-share masked XOR gate
module xor_mask_feeder #(
    parameter int unsigned REFRESH_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    input  logic [31:0] seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        a,
    input  logic        b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        A0,
    output logic        A1,
    output logic        B0,
    output logic        B1,
    output logic        r0,
    output logic        r1,
    output logic        r2,
    output logic        seeded,
    output logic        reseed_req,
    output logic        seed_err
);

    localparam logic [15:0] LIMIT = 16'(REFRESH_LIMIT);

    typedef enum logic [1:0] {
        UNSEEDED  = 2'd0,
        READY     = 2'd1,
        EXHAUSTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] lfsr;
    logic [31:0] lfsr_adv;
    logic [15:0] xfer_cnt;
    logic [15:0] cnt_inc;
    logic        seed_ok;
    logic        seed_bad;
    logic        xfer;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Five fresh bits per transfer: one mask per operand plus three gate randoms
    assign lfsr_adv = lfsr_step(lfsr_step(lfsr_step(lfsr_step(lfsr_step(lfsr)))));
    assign cnt_inc  = xfer_cnt + 16'd1;

    assign seed_ok  = seed_valid && (seed != 32'd0);
    assign seed_bad = seed_valid && (seed == 32'd0);
    assign in_ready = (state == READY) && !seed_valid && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;

    assign seeded     = (state == READY) || (state == EXHAUSTED);
    assign reseed_req = (state == UNSEEDED) || (state == EXHAUSTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UNSEEDED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (seed_ok) begin
            state_nxt = READY;
        end else if (xfer && (cnt_inc == LIMIT)) begin
            state_nxt = EXHAUSTED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= 32'd0;
            xfer_cnt <= 16'd0;
            seed_err <= 1'b0;
        end else begin
            seed_err <= seed_bad;
            if (seed_ok) begin
                lfsr     <= seed;
                xfer_cnt <= 16'd0;
            end else if (xfer) begin
                lfsr     <= lfsr_adv;
                xfer_cnt <= cnt_inc;
            end
        end
    end

    // Seed loads never touch the output register; a pending result drains as-is
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            A0        <= 1'b0;
            A1        <= 1'b0;
            B0        <= 1'b0;
            B1        <= 1'b0;
            r0        <= 1'b0;
            r1        <= 1'b0;
            r2        <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            A0        <= a ^ lfsr_adv[0];
            A1        <= lfsr_adv[0];
            B0        <= b ^ lfsr_adv[1];
            B1        <= lfsr_adv[1];
            r0        <= lfsr_adv[2];
            r1        <= lfsr_adv[3];
            r2        <= lfsr_adv[4];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_mask_feeder.sv
// tb/tb_xor_mask_feeder.sv - self-checking bench for xor_mask_feeder (REFRESH_LIMIT = 4)
module tb_xor_mask_feeder;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid;
    logic [31:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic        a;
    logic        b;
    logic        out_valid;
    logic        out_ready;
    logic        A0, A1, B0, B1, r0, r1, r2;
    logic        seeded;
    logic        reseed_req;
    logic        seed_err;

    int vectors = 0;
    int miscompares = 0;

    xor_mask_feeder #(.REFRESH_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .A0(A0), .A1(A1), .B0(B0), .B1(B1), .r0(r0), .r1(r1), .r2(r2),
        .seeded(seeded), .reseed_req(reseed_req), .seed_err(seed_err)
    );

    always #5 clk = ~clk;

    // Reference model: spec-level state (seeded/exhausted flags, integer count)
    logic [31:0] m_s;
    int          m_cnt;
    bit          m_seeded, m_exh, m_ov, m_err;
    logic [6:0]  m_data;

    function automatic logic [31:0] advance5(input logic [31:0] s);
        logic [31:0] t = s;
        for (int k = 0; k < 5; k++) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        return t;
    endfunction

    task automatic model_reset();
        m_s = 0; m_cnt = 0; m_seeded = 0; m_exh = 0; m_ov = 0; m_err = 0; m_data = '0;
    endtask

    function automatic logic [6:0] dut_data();
        return {A0, A1, B0, B1, r0, r1, r2};
    endfunction

    function automatic logic [10:0] dut_post();
        return {out_valid, dut_data(), seeded, reseed_req, seed_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at negedge, check in_ready before the edge and registered outputs after it
    task automatic cycle(input logic sv, input logic [31:0] sd, input logic iv,
                         input logic ia, input logic ib, input logic ordy,
                         output logic rdy_seen);
        bit m_rdy, xf;
        logic [31:0] s5;
        seed_valid = sv; seed = sd; in_valid = iv; a = ia; b = ib; out_ready = ordy;
        #1;
        m_rdy = m_seeded && !m_exh && !sv && (!m_ov || ordy);
        rdy_seen = in_ready;
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        xf = iv && m_rdy;
        m_err = sv && (sd == 0);
        if (xf) begin
            s5 = advance5(m_s);
            m_data = {ia ^ s5[0], s5[0], ib ^ s5[1], s5[1], s5[2], s5[3], s5[4]};
            m_ov = 1;
            m_s = s5;
            m_cnt++;
            if (m_cnt == LIMIT) m_exh = 1;
        end else if (ordy) begin
            m_ov = 0;
        end
        if (sv && sd != 0) begin
            m_s = sd; m_cnt = 0; m_seeded = 1; m_exh = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("post_edge", 32'(dut_post()),
            32'({m_ov, m_data, m_seeded, m_seeded ? m_exh : 1'b1, m_err}));
    endtask

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        iv, ia, ib, ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic [6:0]  exp_data;
        logic        exp_seeded, exp_rr, exp_err;
    } vec_t;

    vec_t tbl[5];
    logic rs;
    logic [6:0] held;
    int n_rdy;

    initial begin
        tbl[0] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'b1011101, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1011101, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b1011101, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; seed_valid = 0; seed = 0; in_valid = 0; a = 0; b = 0; out_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(dut_post()), 32'({1'b0, 7'b0, 1'b0, 1'b1, 1'b0}));
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        // Directed table: no-seed, seed 1, first transfer, zero seed, idle
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].sv, tbl[i].sd, tbl[i].iv, tbl[i].ia, tbl[i].ib, tbl[i].ordy, rs);
            chk($sformatf("tbl%0d_in_ready", i), 32'(rs), 32'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_outputs", i), 32'(dut_post()),
                32'({tbl[i].exp_ov, tbl[i].exp_data, tbl[i].exp_seeded, tbl[i].exp_rr, tbl[i].exp_err}));
        end

        // Limit: reseed, stream with out_ready high; exactly LIMIT transfers
        cycle(1'b1, 32'hACE1_2345, 1'b0, 1'b0, 1'b0, 1'b1, rs);
        n_rdy = 0;
        for (int i = 0; i < LIMIT + 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'(i), 1'(i >> 1), 1'b1, rs);
            if (rs && i == n_rdy) n_rdy++;
        end
        chk("limit_transfers", 32'(n_rdy), 32'(LIMIT));
        chk("limit_reseed_req", 32'(reseed_req), 32'd1);
        chk("limit_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b1, rs);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, rs);
        chk("reseed_restores_ready", 32'(rs), 32'd1);

        // Backpressure for three cycles, then drain and reload on one edge
        held = dut_data();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, rs);
            chk("stall_in_ready", 32'(rs), 32'd0);
            chk("stall_hold", 32'({out_valid, dut_data()}), 32'({1'b1, held}));
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, rs);
        chk("drain_reload_ready", 32'(rs), 32'd1);
        chk("drain_reload_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset while an output is pending
        #2 rst = 1'b1;
        #1;
        chk("async_reset", 32'(dut_post()), 32'({1'b0, 7'b0, 1'b0, 1'b1, 1'b0}));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, rs);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic sv;
            logic [31:0] sd;
            sv = ($urandom_range(0, 9) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            cycle(sv, sd, 1'($urandom_range(0, 3) != 0), 1'($urandom()), 1'($urandom()),
                  1'($urandom_range(0, 3) != 0), rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xor_mask_feeder.md
XOR_MASK_FEEDER -- requirements
Module: xor_mask_feeder

Interface
REQ-001 Parameter REFRESH_LIMIT, default 1024: accepted transactions allowed per seed before a reseed is required; range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 seed_valid  input  1  seed load strobe.
REQ-005 seed  input  32  LFSR seed value.
REQ-006 in_valid / in_ready  input / output  1 / 1  upstream handshake for one unmasked operand pair.
REQ-007 a, b  input  1 each  unmasked operand bits.
REQ-008 out_valid / out_ready  output / input  1 / 1  downstream handshake toward the masked XOR gate.
REQ-009 A0, A1, B0, B1  output  1 each  2-share masked operands.
REQ-010 r0, r1, r2  output  1 each  fresh gate randomness.
REQ-011 seeded  output  1  high in READY or EXHAUSTED.
REQ-012 reseed_req  output  1  high in UNSEEDED or EXHAUSTED.
REQ-013 seed_err  output  1  one-cycle pulse on rejected seed.

Function
REQ-014 The block SHALL hold a 32-bit Fibonacci LFSR S; one step: fb = S[31]^S[21]^S[1]^S[0], S <= {S[30:0], fb}.
REQ-015 The FSM SHALL have states UNSEEDED, READY and EXHAUSTED.
REQ-016 seed_valid with seed != 0 SHALL load S = seed, clear the transaction counter and enter READY from any state.
REQ-017 seed_valid with seed == 0 SHALL leave S, counter and state unchanged and pulse seed_err high for exactly one cycle.
REQ-018 in_ready SHALL equal (state == READY) & !seed_valid & (!out_valid | out_ready).
REQ-019 A transfer SHALL occur when in_valid & in_ready; S SHALL advance five steps in that cycle (S' = step^5(S)).
REQ-020 On transfer, the output register SHALL load, with 1-cycle latency: A0 = a^S'[0], A1 = S'[0], B0 = b^S'[1], B1 = S'[1], r0 = S'[2], r1 = S'[3], r2 = S'[4]; out_valid SHALL then be set.
REQ-021 out_valid SHALL clear on out_ready unless a new transfer occurs in the same cycle, in which case it SHALL stay high with the new data (back-to-back, full throughput).
REQ-022 While out_valid & !out_ready, all output data SHALL be held stable.
REQ-023 S SHALL NOT advance in cycles without a transfer; no share or random bit SHALL be reused across transfers.
REQ-024 Each transfer SHALL increment a 16-bit counter; when the counter reaches REFRESH_LIMIT the FSM SHALL enter EXHAUSTED on the same edge.
REQ-025 In EXHAUSTED, in_ready SHALL be 0; a pending output SHALL still drain normally.
REQ-026 seed_valid SHALL take priority over a transfer in the same cycle (in_ready forced low per REQ-018).
REQ-027 Loading a seed SHALL NOT modify a pending output register or out_valid.
REQ-028 Unmasked values a and b SHALL never be driven directly onto any output; output share registers SHALL be updated only from the masking equations.

Reset
REQ-029 rst high SHALL immediately force: state = UNSEEDED, S = 0, counter = 0, out_valid = 0, A0..B1 = 0, r0..r2 = 0, seed_err = 0.
REQ-030 After reset release, in_ready SHALL stay 0 until a valid seed is loaded; reset asserted mid-transfer SHALL discard the pending output.

Verification
REQ-031 Reset, then in_valid = 1 with no seed -> in_ready = 0, reseed_req = 1, out_valid = 0.
REQ-032 Seed 0x00000001, then a = 1, b = 0 transferred -> next cycle out_valid = 1, A0 = 1, A1 = 0, B0 = 1, B1 = 1, r0 = 1, r1 = 0, r2 = 1; S = 0x00000036.
REQ-033 Seed 0x00000000 while READY -> seed_err one-cycle pulse; state, S and counter unchanged.
REQ-034 REFRESH_LIMIT = 4, continuous in_valid with out_ready = 1 -> exactly 4 transfers on consecutive cycles, then in_ready = 0 and reseed_req = 1; reseed restores in_ready.
REQ-035 out_ready held 0 for 3 cycles after a transfer -> outputs stable, in_ready = 0; out_ready = 1 with in_valid = 1 -> drain and new load on the same edge.
REQ-036 rst pulsed while out_valid = 1 -> out_valid = 0 asynchronously, all share and random outputs = 0, state UNSEEDED.
